// File: rtl/i2c_slave_tx.sv
// I2C target transmitter: answers master reads addressed to SLAVE_ADDR, shifting
// bytes from a valid/ready source onto an open-drain SDA, MSB first.
`timescale 1ns/1ps
module i2c_slave_tx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       nack,
    output logic       underrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_LOAD, S_TX, S_RX_ACK, S_WAIT_STOP
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] scl_sync_q, sda_sync_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       phase_q, phase_d;
    logic       underrun_q, underrun_d;

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    // Bits [1:0] synchronize, bit [2] is the previous synced value for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl};
            sda_sync_q <= {sda_sync_q[1:0], sda};
        end
    end

    assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
    assign sda_s     =  sda_sync_q[1];
    assign start_det =  scl_sync_q[1] & ~sda_sync_q[1] &  sda_sync_q[2];
    assign stop_det  =  scl_sync_q[1] &  sda_sync_q[1] & ~sda_sync_q[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shreg_q    <= 8'd0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            phase_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
        end
    end

    // phase_q: ADDR_ACK = ACK is being driven; RX_ACK = master ACK already seen
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        phase_d    = phase_q;
        underrun_d = 1'b0;
        if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            phase_d = 1'b0;
        end else if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: oe_d = 1'b0;
                S_ADDR: if (scl_rise) begin
                    shreg_d = {shreg_q[6:0], sda_s};
                    if (cnt_q == 4'd7) begin
                        if (shreg_q[6:0] == SLAVE_ADDR && sda_s) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            cnt_d   = 4'd8;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        oe_d    = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        phase_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    shreg_d    = tx_valid ? tx_data : IDLE_BYTE;
                    oe_d       = ~shreg_d[7];
                    cnt_d      = 4'd0;
                    underrun_d = ~tx_valid;
                    state_d    = S_TX;
                end
                S_TX: if (scl_fall) begin
                    if (cnt_q == 4'd7) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd8;
                        state_d = S_RX_ACK;
                    end else begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        oe_d    = ~shreg_d[7];
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                S_RX_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_s) begin
                            phase_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_WAIT_STOP;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        state_d = S_LOAD;
                    end
                end
                S_WAIT_STOP: oe_d = 1'b0;
                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // underrun is registered so it lands the cycle after tx_ready, never alongside it
    always_comb begin
        tx_ready = 1'b0;
        tx_done  = 1'b0;
        nack     = 1'b0;
        if (!stop_det && !start_det) begin
            case (state_q)
                S_LOAD:   tx_ready = 1'b1;
                S_RX_ACK: if (scl_rise && !phase_q) begin
                    tx_done = ~sda_s;
                    nack    =  sda_s;
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign underrun = underrun_q;
    assign sda      = oe_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_slave_tx.sv
// Bench for i2c_slave_tx: bit-banged I2C master, queued byte source and a
// transaction-level expectation model.
`timescale 1ns/1ps
module tb_i2c_slave_tx;
    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m_low = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, nack, underrun;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = sda_m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_tx #(.SLAVE_ADDR(7'h42), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .reset(rst_n), .scl(scl), .sda(sda_bus),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .tx_done(tx_done), .nack(nack), .underrun(underrun)
    );

    int checks = 0, errors = 0;
    int n_rdy = 0, n_done = 0, n_nack = 0, n_under = 0, n_overlap = 0, n_low = 0;
    logic [7:0] src_q[$];
    int src_rd = 0;

    // Pulse and bus activity counters
    always @(negedge clk) begin
        n_rdy   += int'(tx_ready);
        n_done  += int'(tx_done);
        n_nack  += int'(nack);
        n_under += int'(underrun);
        if (int'(tx_ready) + int'(tx_done) + int'(nack) + int'(underrun) > 1) n_overlap++;
        if (!sda_m_low && sda_bus === 1'b0) n_low++;
    end

    // Byte source: presents the queue head, advances on a tx_ready/tx_valid cycle
    initial begin : src_proc
        logic took;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            took = tx_ready && tx_valid;
            @(posedge clk);
            #1;
            if (took) src_rd++;
            if (src_rd < src_q.size()) begin
                tx_valid = 1'b1;
                tx_data  = src_q[src_rd];
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic m_start();
        clks(Q); sda_m_low = 1'b1; clks(Q); scl = 1'b0;
    endtask

    task automatic m_rstart();
        clks(Q); sda_m_low = 1'b0; clks(Q); scl = 1'b1;
        clks(Q); sda_m_low = 1'b1; clks(Q); scl = 1'b0;
    endtask

    task automatic m_stop();
        clks(Q); sda_m_low = 1'b1; clks(Q); scl = 1'b1;
        clks(Q); sda_m_low = 1'b0; clks(Q);
    endtask

    task automatic send_bit(input logic b);
        clks(Q); sda_m_low = ~b; clks(Q); scl = 1'b1; clks(2 * Q); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        clks(Q); sda_m_low = 1'b0; clks(Q); scl = 1'b1;
        clks(Q); b = (sda_bus === 1'b0) ? 1'b0 : 1'b1; clks(Q); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    // Clock out idle SCL pulses with SDA released and confirm nobody pulls it low
    task automatic idle_pulses(input string nm);
        int l0;
        logic b;
        l0 = n_low;
        for (int i = 0; i < 9; i++) read_bit(b);
        clks(Q); scl = 1'b1; clks(Q);
        chk(nm, n_low - l0, 0);
    endtask

    // One complete master read transaction; bytes beyond ns are expected as IDLE_BYTE
    task automatic run_read(input logic [6:0] a, input logic rw, input int nb, input int ns,
                            input logic [31:0] data, input logic e_ack, input int e_rdy,
                            input int e_done, input int e_nack, input int e_under);
        int r0, d0, k0, u0, l0;
        logic b;
        logic [7:0] v, ev;
        if (e_ack) for (int i = 0; i < ns; i++) src_q.push_back(data[31 - 8 * i -: 8]);
        clks(4);
        r0 = n_rdy; d0 = n_done; k0 = n_nack; u0 = n_under; l0 = n_low;
        m_start();
        send_byte({a, rw});
        read_bit(b);
        chk("addr_ack", b, e_ack ? 1'b0 : 1'b1);
        if (e_ack) begin
            chk("busy_after_match", busy, 1'b1);
            for (int i = 0; i < nb; i++) begin
                read_byte(v);
                ev = (i < ns) ? data[31 - 8 * i -: 8] : 8'hFF;
                chk($sformatf("byte%0d", i), v, ev);
                send_bit(i == nb - 1);
            end
            chk("busy_after_nack", busy, 1'b0);
        end
        m_stop();
        clks(4);
        chk("n_tx_ready", n_rdy - r0, e_rdy);
        chk("n_tx_done", n_done - d0, e_done);
        chk("n_nack", n_nack - k0, e_nack);
        chk("n_underrun", n_under - u0, e_under);
        chk("busy_idle", busy, 1'b0);
        if (!e_ack) chk("no_sda_drive", n_low - l0, 0);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        int          nb;
        int          ns;
        logic [31:0] data;
        logic        e_ack;
        int          e_rdy;
        int          e_done;
        int          e_nack;
        int          e_under;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic        b, rw, ack;
        logic [6:0]  a;
        logic [7:0]  v;
        int          nb, ns, r0, d0, k0, u0;
        logic [31:0] data;

        tbl[0] = '{7'h42, 1'b1, 1, 1, 32'hA500_0000, 1'b1, 1, 0, 1, 0};  // single byte
        tbl[1] = '{7'h42, 1'b1, 3, 3, 32'h0102_0300, 1'b1, 3, 2, 1, 0};  // three bytes
        tbl[2] = '{7'h43, 1'b1, 1, 1, 32'h7700_0000, 1'b0, 0, 0, 0, 0};  // 0x87 mismatch
        tbl[3] = '{7'h42, 1'b0, 1, 1, 32'h7700_0000, 1'b0, 0, 0, 0, 0};  // 0x84 write
        tbl[4] = '{7'h42, 1'b1, 1, 0, 32'h0000_0000, 1'b1, 1, 0, 1, 1};  // underrun
        tbl[5] = '{7'h42, 1'b1, 2, 1, 32'h3C00_0000, 1'b1, 2, 1, 1, 1};  // underrun on 2nd

        clks(3);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        chk("rst_nack", nack, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_sda", sda_bus, 1'b1);
        rst_n = 1'b1;
        clks(4);

        for (int i = 0; i < 6; i++)
            run_read(tbl[i].addr, tbl[i].rw, tbl[i].nb, tbl[i].ns, tbl[i].data,
                     tbl[i].e_ack, tbl[i].e_rdy, tbl[i].e_done, tbl[i].e_nack, tbl[i].e_under);

        // Repeated START after byte 1 ACK: byte 2 is loaded then abandoned
        src_q.push_back(8'hA5); src_q.push_back(8'hC3); src_q.push_back(8'h5A);
        clks(4);
        r0 = n_rdy; d0 = n_done; k0 = n_nack; u0 = n_under;
        m_start();
        send_byte(8'h85);
        read_bit(b);     chk("rs_ack1", b, 1'b0);
        read_byte(v);    chk("rs_byte1", v, 8'hA5);
        send_bit(1'b0);
        m_rstart();
        send_byte(8'h85);
        read_bit(b);     chk("rs_ack2", b, 1'b0);
        chk("rs_busy", busy, 1'b1);
        read_byte(v);    chk("rs_byte2", v, 8'h5A);
        send_bit(1'b1);
        m_stop();
        clks(4);
        chk("rs_n_tx_ready", n_rdy - r0, 3);
        chk("rs_n_tx_done", n_done - d0, 1);
        chk("rs_n_nack", n_nack - k0, 1);
        chk("rs_n_underrun", n_under - u0, 0);

        // STOP in the middle of a byte
        src_q.push_back(8'hA5);
        clks(4);
        r0 = n_rdy; d0 = n_done; k0 = n_nack;
        m_start();
        send_byte(8'h85);
        read_bit(b);     chk("stop_ack", b, 1'b0);
        read_bit(b);     chk("stop_bit7", b, 1'b1);
        read_bit(b);     chk("stop_bit6", b, 1'b0);
        m_stop();
        clks(3);
        chk("stop_busy", busy, 1'b0);
        chk("stop_n_tx_ready", n_rdy - r0, 1);
        chk("stop_n_tx_done", n_done - d0, 0);
        chk("stop_n_nack", n_nack - k0, 0);
        idle_pulses("stop_released");

        // Reset while the target is pulling SDA low for a 0 bit
        src_q.push_back(8'hA5);
        clks(4);
        m_start();
        send_byte(8'h85);
        read_bit(b);     chk("rstmid_ack", b, 1'b0);
        read_bit(b);     chk("rstmid_bit7", b, 1'b1);
        clks(Q);
        chk("rstmid_driving", sda_bus, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_sda_release", sda_bus, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        clks(2);
        rst_n = 1'b1;
        m_stop();
        idle_pulses("rstmid_released");

        // Randomized reads against the transaction-level model
        for (int t = 0; t < 12; t++) begin
            a    = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h42;
            rw   = ($urandom_range(0, 3) != 0);
            nb   = $urandom_range(1, 4);
            ns   = $urandom_range(0, nb);
            data = $urandom;
            ack  = (a == 7'h42) && rw;
            run_read(a, rw, nb, ns, data, ack, ack ? nb : 0, ack ? nb - 1 : 0,
                     ack ? 1 : 0, ack ? nb - ns : 0);
        end

        chk("pulse_overlap", n_overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
